// File: rtl/bcd_entry_n.sv
// bcd_entry_n: keypad BCD operand entry with backspace, clear, invalid-key rejection
// and a shift-register history of committed operands.
`ifndef NEGATIVE
`define NEGATIVE 4'hA
`endif
`ifndef OFF
`define OFF 4'hF
`endif
module bcd_entry_n #(
   parameter int DIGITS     = 3,
   parameter int HIST_DEPTH = 2,
   parameter int IW         = $clog2(DIGITS + 1),
   parameter int HW         = $clog2(HIST_DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             bcd_input,
   input  logic [3:0]                       bcd_num,
   input  logic                             bcd_del,
   input  logic                             bcd_clr,
   input  logic                             sign_on,
   output logic [4*DIGITS-1:0]              curr_value,
   output logic [IW-1:0]                    digit_idx,
   output logic [DIGITS-1:0]                digit_led,
   output logic                             curr_sign_mode,
   output logic [3:0]                       sign,
   output logic [4*DIGITS*HIST_DEPTH-1:0]   hist_value,
   output logic [HIST_DEPTH-1:0]            hist_sign,
   output logic [HW-1:0]                    hist_count,
   output logic                             got_value,
   output logic                             commit,
   output logic                             err
);
   typedef enum logic {ENTRY, FULL} state_t;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
   state_t state, state_n;
   logic in_q, press, commit_n, err_n;
   logic [IW-1:0] idx_n, pos;
   logic [4*DIGITS-1:0] cur_n;
   logic [4*DIGITS-1:0] hist [HIST_DEPTH];
   logic [4*DIGITS-1:0] hist_n [HIST_DEPTH];
   logic [HIST_DEPTH-1:0] hsign_n;
   logic [HW-1:0] hcnt_n;
   assign press = bcd_input & ~in_q;
   // a press in FULL always restarts at digit 0 on a cleared operand
   assign pos = (state == FULL) ? '0 : digit_idx;
   always_comb begin
      state_n  = state;
      idx_n    = digit_idx;
      cur_n    = curr_value;
      hist_n   = hist;
      hsign_n  = hist_sign;
      hcnt_n   = hist_count;
      commit_n = 1'b0;
      err_n    = 1'b0;
      if (bcd_clr) begin
         cur_n   = '0;
         idx_n   = '0;
         state_n = ENTRY;
      end else if (bcd_del) begin
         if (state == ENTRY && digit_idx != '0) begin
            idx_n = digit_idx - IW'(1);
            cur_n[{idx_n, 2'b00} +: 4] = 4'h0;
         end
      end else if (press && bcd_num > 4'd9) begin
         err_n = 1'b1;
      end else if (press) begin
         if (state == FULL) cur_n = '0;
         cur_n[{pos, 2'b00} +: 4] = bcd_num;
         idx_n   = pos + IW'(1);
         state_n = ENTRY;
         if (pos == LAST) begin
            commit_n   = 1'b1;
            state_n    = FULL;
            hist_n[0]  = cur_n;
            hsign_n[0] = curr_sign_mode;
            for (int h = 1; h < HIST_DEPTH; h++) begin
               hist_n[h]  = hist[h-1];
               hsign_n[h] = hist_sign[h-1];
            end
            hcnt_n = hist_count + HW'(hist_count != HW'(HIST_DEPTH));
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ENTRY;
         in_q           <= 1'b0;
         curr_sign_mode <= 1'b0;
         digit_idx      <= '0;
         curr_value     <= '0;
         hist           <= '{default: '0};
         hist_sign      <= '0;
         hist_count     <= '0;
         commit         <= 1'b0;
         err            <= 1'b0;
      end else begin
         state          <= state_n;
         in_q           <= bcd_input;
         curr_sign_mode <= sign_on;
         digit_idx      <= idx_n;
         curr_value     <= cur_n;
         hist           <= hist_n;
         hist_sign      <= hsign_n;
         hist_count     <= hcnt_n;
         commit         <= commit_n;
         err            <= err_n;
      end
   end
   for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
      assign hist_value[g*4*DIGITS +: 4*DIGITS] = hist[g];
   end
   assign got_value = (state == FULL);
   assign digit_led = (state == FULL) ? '0 : DIGITS'(1) << digit_idx;
   assign sign      = curr_sign_mode ? `NEGATIVE : `OFF;
endmodule

// File: tb/tb_bcd_entry_n.sv
// tb_bcd_entry_n: directed scenarios on a 3-digit/2-deep instance and a 4-digit/3-deep instance
module tb_bcd_entry_n;
   localparam logic [3:0] NEG = 4'hA, OFF = 4'hF;
   logic clk = 0, rst = 1, bcd_input = 0, bcd_del = 0, bcd_clr = 0, sign_on = 0;
   logic [3:0] bcd_num = 0;
   logic [11:0] cv; logic [1:0] idx; logic [2:0] led; logic csm; logic [3:0] sg;
   logic [23:0] hv; logic [1:0] hs; logic [1:0] hc; logic gv, cm, er;
   logic [15:0] cv4; logic [2:0] idx4; logic [3:0] led4; logic csm4; logic [3:0] sg4;
   logic [47:0] hv4; logic [2:0] hs4; logic [1:0] hc4; logic gv4, cm4, er4;
   int vec = 0, miss = 0;
   logic c, e;
   always #5 clk = ~clk;
   bcd_entry_n #(.DIGITS(3), .HIST_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .bcd_input(bcd_input), .bcd_num(bcd_num), .bcd_del(bcd_del),
      .bcd_clr(bcd_clr), .sign_on(sign_on), .curr_value(cv), .digit_idx(idx), .digit_led(led),
      .curr_sign_mode(csm), .sign(sg), .hist_value(hv), .hist_sign(hs), .hist_count(hc),
      .got_value(gv), .commit(cm), .err(er));
   bcd_entry_n #(.DIGITS(4), .HIST_DEPTH(3)) dut4 (
      .clk(clk), .rst(rst), .bcd_input(bcd_input), .bcd_num(bcd_num), .bcd_del(bcd_del),
      .bcd_clr(bcd_clr), .sign_on(sign_on), .curr_value(cv4), .digit_idx(idx4), .digit_led(led4),
      .curr_sign_mode(csm4), .sign(sg4), .hist_value(hv4), .hist_sign(hs4), .hist_count(hc4),
      .got_value(gv4), .commit(cm4), .err(er4));
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic press(input logic [3:0] d, output logic pc, output logic pe);
      bcd_num = d; bcd_input = 1; tick();
      pc = cm; pe = er;
      bcd_input = 0; tick();
   endtask
   task automatic test_reset();
      rst = 1; tick(); tick(); rst = 0;
      vec++; if (cv !== 12'h0) begin $display("FAIL reset_cv got %h exp 000", cv); miss++; end
      vec++; if (idx !== 2'd0) begin $display("FAIL reset_idx got %0d exp 0", idx); miss++; end
      vec++; if (led !== 3'b001) begin $display("FAIL reset_led got %b exp 001", led); miss++; end
      vec++; if (sg !== OFF) begin $display("FAIL reset_sign got %h exp %h", sg, OFF); miss++; end
      vec++; if ({hv, hs, hc, gv, cm, er} !== '0) begin $display("FAIL reset_hist got %h/%b/%0d/%b%b%b exp zeros", hv, hs, hc, gv, cm, er); miss++; end
   endtask
   task automatic test_commit();
      sign_on = 0;
      press(4'd3, c, e);
      vec++; if (c !== 1'b0) begin $display("FAIL early_commit got %b exp 0", c); miss++; end
      vec++; if (led !== 3'b010) begin $display("FAIL led_after_1 got %b exp 010", led); miss++; end
      press(4'd2, c, e);
      press(4'd1, c, e);
      vec++; if (c !== 1'b1) begin $display("FAIL commit_pulse got %b exp 1", c); miss++; end
      vec++; if (cm !== 1'b0) begin $display("FAIL commit_one_cycle got %b exp 0", cm); miss++; end
      vec++; if (cv !== 12'h123) begin $display("FAIL commit_cv got %h exp 123", cv); miss++; end
      vec++; if (hv[11:0] !== 12'h123) begin $display("FAIL commit_hist got %h exp 123", hv[11:0]); miss++; end
      vec++; if (hc !== 2'd1) begin $display("FAIL commit_count got %0d exp 1", hc); miss++; end
      vec++; if ({gv, led, idx} !== {1'b1, 3'b000, 2'd3}) begin $display("FAIL commit_full got gv=%b led=%b idx=%0d exp 1/000/3", gv, led, idx); miss++; end
   endtask
   task automatic test_history();
      sign_on = 1; tick();
      vec++; if ({csm, sg} !== {1'b1, NEG}) begin $display("FAIL sign_neg got %b/%h exp 1/%h", csm, sg, NEG); miss++; end
      press(4'd6, c, e); press(4'd5, c, e); press(4'd4, c, e);
      vec++; if ({hv, hs, hc} !== {12'h123, 12'h456, 2'b01, 2'd2}) begin $display("FAIL hist_456 got %h/%b/%0d exp 123456/01/2", hv, hs, hc); miss++; end
      sign_on = 0;
      press(4'd9, c, e); press(4'd8, c, e); press(4'd7, c, e);
      vec++; if ({hv, hs, hc} !== {12'h456, 12'h789, 2'b10, 2'd2}) begin $display("FAIL hist_789 got %h/%b/%0d exp 456789/10/2", hv, hs, hc); miss++; end
      vec++; if (sg !== OFF) begin $display("FAIL sign_off got %h exp %h", sg, OFF); miss++; end
   endtask
   task automatic test_backspace();
      press(4'd5, c, e);
      vec++; if ({gv, cv, idx} !== {1'b0, 12'h005, 2'd1}) begin $display("FAIL restart got %b/%h/%0d exp 0/005/1", gv, cv, idx); miss++; end
      press(4'd7, c, e);
      bcd_del = 1; tick(); bcd_del = 0;
      vec++; if ({cv, idx} !== {12'h005, 2'd1}) begin $display("FAIL del got %h/%0d exp 005/1", cv, idx); miss++; end
      press(4'd9, c, e); press(4'd1, c, e);
      vec++; if ({c, cv} !== {1'b1, 12'h195}) begin $display("FAIL del_commit got %b/%h exp 1/195", c, cv); miss++; end
      bcd_del = 1; tick(); bcd_del = 0;
      vec++; if ({cv, idx, gv} !== {12'h195, 2'd3, 1'b1}) begin $display("FAIL del_full got %h/%0d/%b exp 195/3/1", cv, idx, gv); miss++; end
      vec++; if (hv !== {12'h789, 12'h195}) begin $display("FAIL del_hist got %h exp 789195", hv); miss++; end
   endtask
   task automatic test_invalid();
      press(4'd2, c, e);
      press(4'hC, c, e);
      vec++; if (e !== 1'b1) begin $display("FAIL err_pulse got %b exp 1", e); miss++; end
      vec++; if ({er, cv, idx} !== {1'b0, 12'h002, 2'd1}) begin $display("FAIL err_nochange got %b/%h/%0d exp 0/002/1", er, cv, idx); miss++; end
      bcd_clr = 1; bcd_num = 4'd4; bcd_input = 1; tick();
      vec++; if ({cv, idx, er, led} !== {12'h000, 2'd0, 1'b0, 3'b001}) begin $display("FAIL clr_press got %h/%0d/%b/%b exp 000/0/0/001", cv, idx, er, led); miss++; end
      bcd_clr = 0; bcd_input = 0; tick();
      vec++; if (hv !== {12'h789, 12'h195}) begin $display("FAIL clr_hist got %h exp 789195", hv); miss++; end
   endtask
   task automatic test_hold();
      bcd_num = 4'd6; bcd_input = 1;
      repeat (20) tick();
      bcd_input = 0; tick();
      vec++; if ({cv, idx} !== {12'h006, 2'd1}) begin $display("FAIL hold got %h/%0d exp 006/1", cv, idx); miss++; end
      press(4'd5, c, e); press(4'd4, c, e);
      vec++; if ({c, cv, gv} !== {1'b1, 12'h456, 1'b1}) begin $display("FAIL hold_commit got %b/%h/%b exp 1/456/1", c, cv, gv); miss++; end
      press(4'd8, c, e);
      vec++; if ({gv, cv, idx} !== {1'b0, 12'h008, 2'd1}) begin $display("FAIL after_full got %b/%h/%0d exp 0/008/1", gv, cv, idx); miss++; end
   endtask
   task automatic test_reset_mid();
      press(4'd1, c, e);
      rst = 1; tick(); rst = 0;
      vec++; if ({cv, idx, led, gv, hc, hs, hv} !== {12'h0, 2'd0, 3'b001, 1'b0, 2'd0, 2'b00, 24'h0}) begin $display("FAIL reset_mid got %h/%0d/%b/%b/%0d/%b/%h exp all reset", cv, idx, led, gv, hc, hs, hv); miss++; end
      vec++; if (sg !== OFF) begin $display("FAIL reset_mid_sign got %h exp %h", sg, OFF); miss++; end
   endtask
   task automatic test_wide();
      press(4'd3, c, e); press(4'd2, c, e); press(4'd1, c, e);
      vec++; if ({cm4, cv4, idx4, led4} !== {1'b0, 16'h0123, 3'd3, 4'b1000}) begin $display("FAIL wide_partial got %b/%h/%0d/%b exp 0/0123/3/1000", cm4, cv4, idx4, led4); miss++; end
      press(4'd0, c, e);
      vec++; if ({gv4, led4, idx4, hc4} !== {1'b1, 4'b0000, 3'd4, 2'd1}) begin $display("FAIL wide_full got %b/%b/%0d/%0d exp 1/0000/4/1", gv4, led4, idx4, hc4); miss++; end
      vec++; if (hv4 !== {32'h0, 16'h0123}) begin $display("FAIL wide_hist got %h exp 0123 in entry0", hv4); miss++; end
   endtask
   initial begin
      test_reset();
      test_commit();
      test_history();
      test_backspace();
      test_invalid();
      test_hold();
      test_reset_mid();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/bcd_entry_n.md
Name: bcd_entry_n

Overview:
Parametrised, clocked successor to the three-digit BCD keypad entry block. It collects DIGITS BCD digits, one per debounced key press, least-significant digit first, with a live sign. On the final digit it commits the operand and sign into a HIST_DEPTH-deep history shift register for the downstream ALU/display path. It adds invalid-digit rejection, backspace, clear and a one-hot digit-position LED output.

Parameters:
DIGITS, 3, number of BCD digits per operand (>=1)
HIST_DEPTH, 2, number of committed operands retained (>=1); entry 0 is newest
IW, $clog2(DIGITS+1), width of digit index
HW, $clog2(HIST_DEPTH+1), width of history count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
bcd_input  in  1  debounced key level; a press is its rising edge, detected internally against a registered copy
bcd_num  in  4  digit value, sampled on the press cycle
bcd_del  in  1  single-cycle backspace strobe
bcd_clr  in  1  single-cycle clear of the in-progress entry (history kept)
sign_on  in  1  sign switch level: 1 = negative
curr_value  out  4*DIGITS  in-progress digits; digit k at [4k+3:4k]
digit_idx  out  IW  next digit position to be written
digit_led  out  DIGITS  one-hot of digit_idx; all-zero in FULL
curr_sign_mode  out  1  registered copy of sign_on
sign  out  4  `NEGATIVE when curr_sign_mode, else `OFF (constants.vh)
hist_value  out  4*DIGITS*HIST_DEPTH  committed operands; entry h at slice h
hist_sign  out  HIST_DEPTH  sign of each history entry
hist_count  out  HW  valid history entries, saturates at HIST_DEPTH
got_value  out  1  high while a freshly committed operand is held (FULL state)
commit  out  1  one-cycle pulse on the commit cycle
err  out  1  one-cycle pulse on a rejected press

Behaviour:
- All state updates on posedge clk. Synchronous active-high reset: all outputs 0 except sign = `OFF and digit_led = 1 (bit 0). The internal bcd_input copy is 0, so a key held through reset registers as a press on the first cycle after release of rst.
- press = bcd_input & ~bcd_input_q. One press is handled per rising edge. Holding the key produces no repeats.
- curr_sign_mode and sign follow sign_on with 1-cycle latency.
- States: ENTRY and FULL. Reset state is ENTRY.
- ENTRY, valid press (bcd_num <= 9):
  - Write the digit at digit_idx, then increment digit_idx.
  - If the written digit was index DIGITS-1, commit in the same cycle.
- Commit:
  - Shift the history: h <- h-1 for h >= 1, entry 0 <- the full operand including the final digit.
  - hist_sign[0] <- curr_sign_mode as registered on that cycle.
  - hist_count increments and saturates at HIST_DEPTH.
  - commit pulses; next cycle got_value = 1 and the state is FULL.
  - curr_value holds the operand; digit_idx = DIGITS.
- FULL, valid press:
  - Start a new entry: curr_value is cleared and digit 0 <- bcd_num.
  - digit_idx = 1, got_value = 0, state goes to ENTRY.
  - With DIGITS = 1, this press commits immediately and the state stays FULL.
- Invalid press (bcd_num > 9): no state change; err pulses for 1 cycle. This applies in any state.
- bcd_del:
  - In ENTRY with digit_idx > 0: decrement digit_idx and zero that digit.
  - With digit_idx = 0: no-op.
  - In FULL: ignored, since a committed operand is immutable.
- bcd_clr:
  - Zeros curr_value and sets digit_idx = 0, state ENTRY, got_value = 0.
  - History is untouched.
- Priority within a cycle: rst > bcd_clr > bcd_del > press. A lower-priority event in the same cycle is dropped (no err pulse).
- hist_value and hist_sign change only on commit or rst.
- Arithmetic: digit_idx never exceeds DIGITS; hist_count never exceeds HIST_DEPTH; there is no wrap-around.

Test Plan:
- Reset, then presses 3, 2, 1 with sign_on = 0 -> curr_value = 12'h123, commit pulse on the third press, hist_value[11:0] = 12'h123, hist_count = 1, got_value = 1, digit_led = 0.
- Commit 123, then 456 with sign_on = 1, then 789 -> entry0 = 789, entry1 = 456, hist_sign = 2'b10, hist_count saturates at 2, and 123 is discarded.
- Presses 5, 7, then bcd_del, then 9, 1 -> digit sequence 5, 9, 1, so curr_value = 12'h195 and it commits; bcd_del in FULL leaves 195 intact.
- Press with bcd_num = 4'hC mid-entry -> err pulses for 1 cycle, digit_idx unchanged; bcd_clr together with a press -> curr_value = 0, digit_idx = 0, no err.
- Hold bcd_input high for 20 cycles -> exactly one digit captured. After commit, press 8 -> got_value = 0, curr_value = 12'h008, digit_idx = 1.
- Assert rst after two digits -> all outputs reset, history empty; rerun the first scenario with DIGITS = 4, HIST_DEPTH = 3.
